mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mips_funct_decode.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU operations and the
// multi-cycle sequencer's state and mux-select types.
package mips_pkg;

  localparam logic [5:0] OP_ZERO  = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ZERO = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_ABS = 3'd6
  } t_alu_opcode;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC,
    R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL, HALT
  } t_mc_state;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'd0,
    SRC_B_FOUR    = 2'd1,
    SRC_B_IMM     = 2'd2,
    SRC_B_IMM_SH2 = 2'd3
  } t_alu_src_b;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } t_pc_source;

endpackage

// File: rtl/mips_funct_decode.sv
// R-type funct field to ALU operation; valid is low for unsupported functs.
import mips_pkg::*;

module mips_funct_decode (
  input  logic [5:0]  funct,
  output t_alu_opcode alu_control,
  output logic        valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: one ALU and one memory port shared across
// FETCH/DECODE/EXEC/MEM/WB steps, with memory timeout and halt handling.
import mips_pkg::*;

module mips_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output t_alu_opcode      alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic             mem_err,
  output logic             halted,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  t_mc_state         state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              illegal_reg, mem_err_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic              retire, timeout;
  t_alu_opcode       funct_alu;
  logic              funct_valid;

  // The branch decision is made in the datapath from pc_write_cond and alu_zero.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  mips_funct_decode u_funct_decode (
    .funct       (funct),
    .alu_control (funct_alu),
    .valid       (funct_valid)
  );

  // Timeout fires on the MEM_TIMEOUT-th waiting cycle; mem_ready wins a tie.
  assign timeout = (state_reg inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready &&
                   (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
                else if (timeout) state_next = HALT;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_ZERO: begin
            if (funct == FN_ZERO) retire = 1'b1;
            else if (funct_valid) state_next = R_EXEC;
            else state_next = ILLEGAL;
          end
          OP_ADDI, OP_ADDIU, OP_ABS: state_next = I_EXEC;
          OP_BEQ:  state_next = BRANCH;
          OP_JUMP: state_next = JUMP;
          default: state_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_next = MEM_WB;
                else if (timeout) state_next = HALT;
      MEM_WR:   if (mem_ready) retire = 1'b1;
                else if (timeout) state_next = HALT;
      R_EXEC:   state_next = R_WB;
      I_EXEC:   state_next = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
      ILLEGAL:  state_next = HALT;
      HALT:     if (!halt && !illegal_reg && !mem_err_reg) state_next = FETCH;
      default:  state_next = FETCH;
    endcase
    if (retire) state_next = halt ? HALT : FETCH;
  end

  // Moore decode; reset forces every control low immediately.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    alu_control   = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   alu_src_b = SRC_B_IMM_SH2;
        MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRC_B_IMM; end
        MEM_RD:   begin mem_req = 1'b1; i_or_d = 1'b1; end
        MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        MEM_WR:   begin mem_req = 1'b1; mem_we = 1'b1; i_or_d = 1'b1; end
        R_EXEC:   begin alu_src_a = 1'b1; alu_control = funct_alu; end
        R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = funct_alu; end
        I_EXEC: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRC_B_IMM;
          alu_control = (opcode == OP_ABS) ? ALU_ABS : ALU_ADD;
        end
        I_WB:     reg_write = 1'b1;
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_control   = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
        end
        JUMP:     begin pc_write = 1'b1; pc_source = PC_SRC_JUMP; end
        HALT:     halted = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      mem_err_reg  <= 1'b0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= (state_next != state_reg) ? '0 : wait_cnt_reg + 1'b1;
      if (state_reg == ILLEGAL) illegal_reg <= 1'b1;
      if (timeout) mem_err_reg <= 1'b1;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign illegal_instr = illegal_reg;
  assign mem_err       = mem_err_reg;
  assign instr_retired = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; control outputs are compared as one
// packed vector against hand-derived per-state values.
import mips_pkg::*;

module tb_mips_multicycle_ctrl;

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source[1:0],
  //  alu_src_a, alu_src_b[1:0], alu_control[2:0], reg_dst, mem_to_reg, reg_write, halted}
  localparam logic [17:0] V_FETCH_RDY  = 18'b1_0_0_1_1_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] V_FETCH_WAIT = 18'b1_0_0_0_0_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] V_DECODE     = 18'b0_0_0_0_0_0_00_0_11_000_0_0_0_0;
  localparam logic [17:0] V_MEM_ADDR   = 18'b0_0_0_0_0_0_00_1_10_000_0_0_0_0;
  localparam logic [17:0] V_MEM_RD     = 18'b1_0_1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [17:0] V_MEM_WB     = 18'b0_0_0_0_0_0_00_0_00_000_0_1_1_0;
  localparam logic [17:0] V_MEM_WR     = 18'b1_1_1_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [17:0] V_I_EXEC_ABS = 18'b0_0_0_0_0_0_00_1_10_110_0_0_0_0;
  localparam logic [17:0] V_I_WB       = 18'b0_0_0_0_0_0_00_0_00_000_0_0_1_0;
  localparam logic [17:0] V_BRANCH     = 18'b0_0_0_0_0_1_01_1_00_001_0_0_0_0;
  localparam logic [17:0] V_JUMP       = 18'b0_0_0_0_1_0_10_0_00_000_0_0_0_0;
  localparam logic [17:0] V_HALT       = 18'b0_0_0_0_0_0_00_0_00_000_0_0_0_1;
  localparam logic [17:0] V_ZERO       = 18'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h0;
  logic [5:0]  funct = 6'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt = 1'b0;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write;
  t_alu_opcode alu_control;
  logic        illegal_instr, mem_err, halted;
  logic [31:0] instr_retired;

  int     errors = 0;
  int     checks = 0;
  int     exp_ret = 0;
  longint cyc = 0;
  longint start;

  wire [17:0] ctrl_vec = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                          pc_source, alu_src_a, alu_src_b, alu_control, reg_dst,
                          mem_to_reg, reg_write, halted};

  mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .halt(halt), .mem_req(mem_req), .mem_we(mem_we),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .mem_err(mem_err), .halted(halted), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each task starts just after a falling edge with the FSM in FETCH.
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctrl_vec !== V_ZERO) begin errors++; $display("FAIL reset_ctrl: got %h want %h", ctrl_vec, V_ZERO); end
    checks++; if ({illegal_instr, mem_err} !== 2'b00 || instr_retired !== 32'd0) begin errors++; $display("FAIL reset_flags: got ill=%b err=%b ret=%0d want 0 0 0", illegal_instr, mem_err, instr_retired); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (ctrl_vec !== V_FETCH_WAIT) begin errors++; $display("FAIL reset_fetch: got %h want %h", ctrl_vec, V_FETCH_WAIT); end
    exp_ret = 0;
    $display("reset: ctrl=%h retired=%0d", ctrl_vec, instr_retired);
  endtask

  task automatic test_rtype(input logic [5:0] fn, input t_alu_opcode alu);
    logic [17:0] v_exec, v_wb;
    v_exec = {11'b0_0_0_0_0_0_00_1_00, alu, 4'b0000};
    v_wb   = {11'b0, alu, 4'b1010};
    opcode = OP_ZERO; funct = fn; mem_ready = 1'b1; start = cyc; #1;
    checks++; if (ctrl_vec !== V_FETCH_RDY) begin errors++; $display("FAIL r_fetch: got %h want %h", ctrl_vec, V_FETCH_RDY); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== V_DECODE) begin errors++; $display("FAIL r_decode: got %h want %h", ctrl_vec, V_DECODE); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== v_exec) begin errors++; $display("FAIL r_exec: got %h want %h", ctrl_vec, v_exec); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== v_wb) begin errors++; $display("FAIL r_wb: got %h want %h", ctrl_vec, v_wb); end
    @(negedge clk); mem_ready = 1'b0; #1; exp_ret++;
    checks++; if (instr_retired !== 32'(exp_ret) || cyc - start != 4) begin errors++; $display("FAIL r_retire: got ret=%0d cyc=%0d want ret=%0d cyc=4", instr_retired, cyc - start, exp_ret); end
    $display("rtype funct=%h: alu=%0d retired=%0d cycles=%0d", fn, alu, instr_retired, cyc - start);
  endtask

  task automatic test_lw_wait();
    int req_cnt;
    opcode = OP_LW; start = cyc; req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      req_cnt += int'(mem_req);
      checks++; if (ctrl_vec !== ((i == 3) ? V_FETCH_RDY : V_FETCH_WAIT)) begin errors++; $display("FAIL lw_fetch%0d: got %h", i, ctrl_vec); end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    checks++; if (ctrl_vec !== V_DECODE) begin errors++; $display("FAIL lw_decode: got %h want %h", ctrl_vec, V_DECODE); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== V_MEM_ADDR) begin errors++; $display("FAIL lw_addr: got %h want %h", ctrl_vec, V_MEM_ADDR); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      req_cnt += int'(mem_req);
      checks++; if (ctrl_vec !== V_MEM_RD) begin errors++; $display("FAIL lw_rd%0d: got %h want %h", i, ctrl_vec, V_MEM_RD); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++; if (ctrl_vec !== V_MEM_WB) begin errors++; $display("FAIL lw_wb: got %h want %h", ctrl_vec, V_MEM_WB); end
    @(negedge clk); #1; exp_ret++;
    checks++; if (cyc - start != 11 || req_cnt != 8 || instr_retired !== 32'(exp_ret)) begin errors++; $display("FAIL lw_total: got cyc=%0d req=%0d ret=%0d want 11 8 %0d", cyc - start, req_cnt, instr_retired, exp_ret); end
    $display("lw 3-wait: cycles=%0d req_cycles=%0d retired=%0d", cyc - start, req_cnt, instr_retired);
  endtask

  task automatic test_branch_jump();
    for (int k = 0; k < 3; k++) begin
      opcode = (k == 2) ? OP_JUMP : OP_BEQ; alu_zero = (k == 0);
      mem_ready = 1'b1; start = cyc; #1;
      @(negedge clk); #1;
      checks++; if (ctrl_vec !== V_DECODE) begin errors++; $display("FAIL bj_decode%0d: got %h want %h", k, ctrl_vec, V_DECODE); end
      @(negedge clk); #1;
      checks++; if (ctrl_vec !== ((k == 2) ? V_JUMP : V_BRANCH)) begin errors++; $display("FAIL bj_exec%0d: got %h", k, ctrl_vec); end
      @(negedge clk); mem_ready = 1'b0; #1; exp_ret++;
      checks++; if (cyc - start != 3 || instr_retired !== 32'(exp_ret) || ctrl_vec !== V_FETCH_WAIT) begin errors++; $display("FAIL bj_retire%0d: got cyc=%0d ret=%0d want 3 %0d", k, cyc - start, instr_retired, exp_ret); end
      $display("%s alu_zero=%b: cycles=%0d retired=%0d", (k == 2) ? "jump" : "beq", alu_zero, cyc - start, instr_retired);
    end
  endtask

  task automatic test_itype_nop();
    opcode = OP_ABS; mem_ready = 1'b1; start = cyc;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctrl_vec !== V_I_EXEC_ABS) begin errors++; $display("FAIL abs_exec: got %h want %h", ctrl_vec, V_I_EXEC_ABS); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== V_I_WB) begin errors++; $display("FAIL abs_wb: got %h want %h", ctrl_vec, V_I_WB); end
    @(negedge clk); opcode = OP_ZERO; funct = FN_ZERO; #1; exp_ret++;
    checks++; if (cyc - start != 4 || instr_retired !== 32'(exp_ret)) begin errors++; $display("FAIL abs_retire: got cyc=%0d ret=%0d want 4 %0d", cyc - start, instr_retired, exp_ret); end
    start = cyc;
    repeat (2) @(negedge clk);
    #1; exp_ret++;
    checks++; if (cyc - start != 2 || instr_retired !== 32'(exp_ret) || ctrl_vec !== V_FETCH_RDY) begin errors++; $display("FAIL nop: got cyc=%0d ret=%0d ctrl=%h want 2 %0d %h", cyc - start, instr_retired, ctrl_vec, exp_ret, V_FETCH_RDY); end
    mem_ready = 1'b0;
    $display("abs+nop: retired=%0d", instr_retired);
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++; if (ctrl_vec !== V_ZERO || illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_state: got %h ill=%b want %h 0", ctrl_vec, illegal_instr, V_ZERO); end
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== V_HALT || illegal_instr !== 1'b1) begin errors++; $display("FAIL ill_halt: got %h ill=%b want %h 1", ctrl_vec, illegal_instr, V_HALT); end
    @(negedge clk); halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctrl_vec !== V_HALT || illegal_instr !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %h ill=%b want %h 1", ctrl_vec, illegal_instr, V_HALT); end
    rst_n = 1'b0; #1;
    checks++; if (illegal_instr !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL ill_reset: got ill=%b halted=%b want 0 0", illegal_instr, halted); end
    @(negedge clk); rst_n = 1'b1; exp_ret = 0; #1;
    $display("illegal 0x3F: cleared by reset, ctrl=%h", ctrl_vec);
  endtask

  task automatic test_timeout(input bit ready_on_last);
    opcode = OP_SW; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk); mem_ready = ready_on_last && (i == 254); #1;
      if (i == 0) begin checks++; if (ctrl_vec !== V_MEM_WR) begin errors++; $display("FAIL to_wr: got %h want %h", ctrl_vec, V_MEM_WR); end end
      if (i == 254) begin checks++; if (mem_req !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL to_edge: got req=%b err=%b want 1 0", mem_req, mem_err); end end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    if (!ready_on_last) begin
      checks++; if (mem_err !== 1'b1 || ctrl_vec !== V_HALT) begin errors++; $display("FAIL to_err: got err=%b ctrl=%h want 1 %h", mem_err, ctrl_vec, V_HALT); end
      @(negedge clk); rst_n = 1'b0; #1;
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_clear: got err=%b want 0", mem_err); end
      @(negedge clk); rst_n = 1'b1; exp_ret = 0; #1;
    end else begin
      exp_ret++;
      checks++; if (mem_err !== 1'b0 || ctrl_vec !== V_FETCH_WAIT || instr_retired !== 32'(exp_ret)) begin errors++; $display("FAIL to_tie: got err=%b ctrl=%h ret=%0d want 0 %h %0d", mem_err, ctrl_vec, instr_retired, V_FETCH_WAIT, exp_ret); end
    end
    $display("sw timeout ready_on_last=%b: mem_err=%b retired=%0d", ready_on_last, mem_err, instr_retired);
  endtask

  task automatic test_back_to_back();
    opcode = OP_ZERO; funct = FN_ADD; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    halt = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (ctrl_vec !== 18'b0_0_0_0_0_0_00_0_00_000_1_0_1_0) begin errors++; $display("FAIL bb_rwb: got %h", ctrl_vec); end
    @(negedge clk); #1; exp_ret++;
    checks++; if (ctrl_vec !== V_HALT || instr_retired !== 32'(exp_ret)) begin errors++; $display("FAIL bb_halt: got %h ret=%0d want %h %0d", ctrl_vec, instr_retired, V_HALT, exp_ret); end
    @(negedge clk); halt = 1'b0; #1;
    checks++; if (ctrl_vec !== V_HALT) begin errors++; $display("FAIL bb_hold: got %h want %h", ctrl_vec, V_HALT); end
    @(negedge clk); opcode = OP_LW; mem_ready = 1'b1; #1;
    checks++; if (ctrl_vec !== V_FETCH_RDY) begin errors++; $display("FAIL bb_release: got %h want %h", ctrl_vec, V_FETCH_RDY); end
    @(negedge clk); mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctrl_vec !== V_MEM_RD) begin errors++; $display("FAIL bb_memrd: got %h want %h", ctrl_vec, V_MEM_RD); end
    rst_n = 1'b0; #1;
    checks++; if (ctrl_vec !== V_ZERO || instr_retired !== 32'd0) begin errors++; $display("FAIL bb_rst: got %h ret=%0d want %h 0", ctrl_vec, instr_retired, V_ZERO); end
    @(negedge clk); rst_n = 1'b1; exp_ret = 0; #1;
    checks++; if (ctrl_vec !== V_FETCH_WAIT) begin errors++; $display("FAIL bb_refetch: got %h want %h", ctrl_vec, V_FETCH_WAIT); end
    $display("halt/reset sequence: ctrl=%h retired=%0d", ctrl_vec, instr_retired);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype(FN_ADD, ALU_ADD);
    test_rtype(FN_SLT, ALU_SLT);
    test_lw_wait();
    test_branch_jump();
    test_itype_nop();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
